// File: rtl/line_arb.sv
// -----------------------------------------------------------------------------
// line_arb -- round-robin arbiter for a shared call line across four handsets.
//
// One handset at a time owns the line. The owner is chosen round-robin from
// the handset after the previous owner. The arbiter strobes the call channel
// to dial, end or cancel a call, and releases the line when the call is over.
//
// Optional feature (macro LINE_ARB_GUARD_EN):
//   defined   : after every release the line stays idle for GUARD_CYCLES
//               cycles (GUARD state, 8-bit down-counter) before a new grant.
//   undefined : RELEASE returns straight to IDLE; GUARD_CYCLES is only
//               range-checked.
//
// Ports:
//   clk               in   clock, all state updates on its rising edge
//   reset_n           in   asynchronous active-low reset
//   req[3:0]          in   per-handset line request (level)
//   rel[3:0]          in   per-handset hang-up pulse (only grantee's bit used)
//   line_in_call      in   channel reports a call in progress
//   line_call_ended   in   channel reports the far end hung up
//   line_dial_timeout in   channel reports dialling timed out
//   line_call_timeout in   channel reports call timed out
//   gnt[3:0]          out  one-hot grant, zero when the line is free
//   gnt_id[1:0]       out  index of the grantee, holds when gnt is zero
//   line_dial         out  one-cycle dial strobe
//   line_end          out  one-cycle end-call strobe
//   line_cancel       out  one-cycle cancel strobe
//   busy              out  high in every state except IDLE
//   state_dbg[2:0]    out  current FSM state encoding, for observation
//
// Request/grant handshake: req is a level held by the handset for as long as
// it wants the line. A grant is issued only from IDLE, one cycle after req is
// sampled, and is kept until the call is released. req dropping while owned
// counts as a hang-up. Requests seen outside IDLE are not remembered; a
// handset that still holds req is considered again on the next IDLE cycle.
// -----------------------------------------------------------------------------
module line_arb #(
    parameter int NUM_REQ      = 4,
    parameter int GUARD_CYCLES = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] req,
    input  logic [3:0] rel,
    input  logic       line_in_call,
    input  logic       line_call_ended,
    input  logic       line_dial_timeout,
    input  logic       line_call_timeout,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       line_dial,
    output logic       line_end,
    output logic       line_cancel,
    output logic       busy,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GRANT   = 3'd1,
        ACTIVE  = 3'd2,
        CANCEL  = 3'd3,
        RELEASE = 3'd4,
        GUARD   = 3'd5
    } state_t;

    // Elaboration-time parameter checks.
    if (NUM_REQ != 4) begin : g_bad_num_req
        $error("line_arb: NUM_REQ must be 4");
    end
    if (GUARD_CYCLES < 1 || GUARD_CYCLES > 255) begin : g_bad_guard
        $error("line_arb: GUARD_CYCLES must be in 1..255");
    end

    state_t     state;
    state_t     state_nxt;
    logic [3:0] gnt_nxt;
    logic [1:0] gnt_id_nxt;
    logic [1:0] ptr;
    logic [1:0] ptr_nxt;

    // Round-robin search result.
    logic       sel_found;
    logic [1:0] sel_id;
    logic [1:0] cand;

`ifdef LINE_ARB_GUARD_EN
    logic [7:0] guard_cnt;
    logic [7:0] guard_cnt_nxt;
`endif

    // -------------------------------------------------------------------------
    // Round-robin pick: first set req bit starting at ptr+1, wrapping mod 4.
    // The last candidate (i = 4) is ptr itself, so the previous owner is
    // served only when nobody else is asking.
    // -------------------------------------------------------------------------
    always_comb begin
        sel_found = 1'b0;
        sel_id    = ptr;
        cand      = '0;
        for (int i = 1; i <= 4; i++) begin
            cand = ptr + 2'(i);
            if (!sel_found && req[cand]) begin
                sel_found = 1'b1;
                sel_id    = cand;
            end
        end
    end

    // -------------------------------------------------------------------------
    // State register and datapath registers.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            gnt    <= '0;
            gnt_id <= '0;
            ptr    <= 2'd3;
        end else begin
            state  <= state_nxt;
            gnt    <= gnt_nxt;
            gnt_id <= gnt_id_nxt;
            ptr    <= ptr_nxt;
        end
    end

`ifdef LINE_ARB_GUARD_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            guard_cnt <= '0;
        end else begin
            guard_cnt <= guard_cnt_nxt;
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Next-state and strobe logic. The strobes are decoded from the current
    // state so that reset (which forces IDLE) silences them immediately.
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt   = state;
        gnt_nxt     = gnt;
        gnt_id_nxt  = gnt_id;
        ptr_nxt     = ptr;
        line_dial   = 1'b0;
        line_end    = 1'b0;
        line_cancel = 1'b0;
`ifdef LINE_ARB_GUARD_EN
        guard_cnt_nxt = guard_cnt;
`endif

        case (state)
            IDLE: begin
                if (sel_found) begin
                    gnt_nxt    = 4'b0001 << sel_id;
                    gnt_id_nxt = sel_id;
                    state_nxt  = GRANT;
                end
            end

            GRANT: begin
                line_dial = 1'b1;
                state_nxt = ACTIVE;
            end

            ACTIVE: begin
                // Channel timeouts outrank any hang-up from the handset.
                if (line_dial_timeout || line_call_timeout) begin
                    state_nxt = CANCEL;
                end else if (line_call_ended) begin
                    state_nxt = RELEASE;
                end else if (rel[gnt_id] || !req[gnt_id]) begin
                    // Only a connected call needs an explicit end strobe.
                    line_end  = line_in_call;
                    state_nxt = RELEASE;
                end
            end

            CANCEL: begin
                line_cancel = 1'b1;
                state_nxt   = RELEASE;
            end

            RELEASE: begin
                gnt_nxt = '0;
                ptr_nxt = gnt_id;
`ifdef LINE_ARB_GUARD_EN
                guard_cnt_nxt = 8'(GUARD_CYCLES - 1);
                state_nxt     = GUARD;
`else
                state_nxt     = IDLE;
`endif
            end

`ifdef LINE_ARB_GUARD_EN
            GUARD: begin
                if (guard_cnt == 8'd0) begin
                    state_nxt = IDLE;
                end else begin
                    guard_cnt_nxt = guard_cnt - 8'd1;
                end
            end
`endif

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy      = (state != IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_line_arb.sv
// -----------------------------------------------------------------------------
// tb_line_arb -- directed bench for line_arb.
// Inputs change 1 time unit after the rising edge; registered outputs are
// checked at that point too, combinational strobes 1 unit after the inputs.
// -----------------------------------------------------------------------------
module tb_line_arb;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_GRANT   = 3'd1;
    localparam logic [2:0] S_ACTIVE  = 3'd2;
    localparam logic [2:0] S_CANCEL  = 3'd3;
    localparam logic [2:0] S_RELEASE = 3'd4;
    localparam logic [2:0] S_GUARD   = 3'd5;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] req;
    logic [3:0] rel;
    logic       line_in_call;
    logic       line_call_ended;
    logic       line_dial_timeout;
    logic       line_call_timeout;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       line_dial;
    logic       line_end;
    logic       line_cancel;
    logic       busy;
    logic [2:0] state_dbg;

    int n_vec = 0;
    int n_err = 0;

    logic [3:0] exp_g [4];

    line_arb #(
        .NUM_REQ      (4),
        .GUARD_CYCLES (8)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .req               (req),
        .rel               (rel),
        .line_in_call      (line_in_call),
        .line_call_ended   (line_call_ended),
        .line_dial_timeout (line_dial_timeout),
        .line_call_timeout (line_call_timeout),
        .gnt               (gnt),
        .gnt_id            (gnt_id),
        .line_dial         (line_dial),
        .line_end          (line_end),
        .line_cancel       (line_cancel),
        .busy              (busy),
        .state_dbg         (state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        req               = '0;
        rel               = '0;
        line_in_call      = 1'b0;
        line_call_ended   = 1'b0;
        line_dial_timeout = 1'b0;
        line_call_timeout = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        clear_inputs();
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    // Bounded wait for the FSM to come back to IDLE.
    task automatic to_idle();
        for (int i = 0; i < 300 && state_dbg != S_IDLE; i++) tick();
        chk("reach_idle", {5'd0, state_dbg}, {5'd0, S_IDLE});
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        exp_g[0] = 4'b0001;
        exp_g[1] = 4'b0010;
        exp_g[2] = 4'b0100;
        exp_g[3] = 4'b1000;

        // Reset values.
        do_reset();
        chk("rst_gnt",    {4'd0, gnt},    8'h00);
        chk("rst_gnt_id", {6'd0, gnt_id}, 8'h00);
        chk("rst_busy",   {7'd0, busy},   8'h00);
        chk("rst_state",  {5'd0, state_dbg}, {5'd0, S_IDLE});

        // Scenario 1: req=0101 -> handset 0 first (ptr=3 after reset).
        req = 4'b0101;
        tick();
        chk("s1_gnt",    {4'd0, gnt},       8'h01);
        chk("s1_gnt_id", {6'd0, gnt_id},    8'h00);
        chk("s1_dial",   {7'd0, line_dial}, 8'h01);
        chk("s1_state",  {5'd0, state_dbg}, {5'd0, S_GRANT});
        chk("s1_busy",   {7'd0, busy},      8'h01);
        tick();
        chk("s1_active", {5'd0, state_dbg}, {5'd0, S_ACTIVE});
        chk("s1_dial_0", {7'd0, line_dial}, 8'h00);
        chk("s1_gnt_hold", {4'd0, gnt},     8'h01);

        // Scenario 2: handset 0 in call hangs up -> line_end, then next grant.
        line_in_call = 1'b1;
        rel          = 4'b0001;
        #1;
        chk("s2_end", {7'd0, line_end}, 8'h01);
        tick();
        rel          = 4'b0000;
        line_in_call = 1'b0;
        chk("s2_release", {5'd0, state_dbg}, {5'd0, S_RELEASE});
        chk("s2_end_0",   {7'd0, line_end},  8'h00);
        tick();
        chk("s2_gnt_clr", {4'd0, gnt},       8'h00);
`ifdef LINE_ARB_GUARD_EN
        for (int i = 0; i < 8; i++) begin
            chk("s2_guard_state", {5'd0, state_dbg}, {5'd0, S_GUARD});
            chk("s2_guard_busy",  {7'd0, busy},      8'h01);
            tick();
        end
`endif
        chk("s2_idle",   {5'd0, state_dbg}, {5'd0, S_IDLE});
        chk("s2_busy_0", {7'd0, busy},      8'h00);
        tick();
        chk("s2_next_gnt", {4'd0, gnt},    8'h04);
        chk("s2_next_id",  {6'd0, gnt_id}, 8'h02);
        tick();
        chk("s2_active", {5'd0, state_dbg}, {5'd0, S_ACTIVE});

        // Scenario 3: dial timeout and hang-up together -> CANCEL wins.
        line_dial_timeout = 1'b1;
        rel               = 4'b0100;
        line_in_call      = 1'b1;
        #1;
        chk("s3_no_end", {7'd0, line_end}, 8'h00);
        tick();
        clear_inputs();
        chk("s3_cancel_state", {5'd0, state_dbg}, {5'd0, S_CANCEL});
        chk("s3_cancel",       {7'd0, line_cancel}, 8'h01);
        chk("s3_no_end2",      {7'd0, line_end},    8'h00);
        tick();
        chk("s3_release",  {5'd0, state_dbg},   {5'd0, S_RELEASE});
        chk("s3_cancel_0", {7'd0, line_cancel}, 8'h00);
        to_idle();

        // Scenario 4: req=1111 held -> strict rotation 0,1,2,3.
        do_reset();
        req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("s4_gnt",    {4'd0, gnt},    {4'd0, exp_g[k]});
            chk("s4_gnt_id", {6'd0, gnt_id}, 8'(k));
            chk("s4_onehot", {7'd0, $onehot(gnt)}, 8'h01);
            tick();
            chk("s4_active",  {5'd0, state_dbg}, {5'd0, S_ACTIVE});
            chk("s4_gnt_act", {4'd0, gnt},       {4'd0, exp_g[k]});
            rel = exp_g[k];
            tick();
            rel = 4'b0000;
            if (k == 3) req = 4'b0000;
            chk("s4_release", {5'd0, state_dbg}, {5'd0, S_RELEASE});
            to_idle();
        end

        // Scenario 5: grantee drops req with no call -> RELEASE, no line_end.
        req = 4'b0010;
        tick();
        chk("s5_gnt", {4'd0, gnt}, 8'h02);
        tick();
        chk("s5_active", {5'd0, state_dbg}, {5'd0, S_ACTIVE});
        req = 4'b0000;
        #1;
        chk("s5_no_end", {7'd0, line_end}, 8'h00);
        tick();
        chk("s5_release", {5'd0, state_dbg}, {5'd0, S_RELEASE});
        chk("s5_no_end2", {7'd0, line_end},  8'h00);
        to_idle();

        // Scenario 6: reset mid-ACTIVE clears everything at once.
        req = 4'b0001;
        tick();
        chk("s6_gnt", {4'd0, gnt}, 8'h01);
        tick();
        chk("s6_active", {5'd0, state_dbg}, {5'd0, S_ACTIVE});
        line_in_call = 1'b1;
        reset_n      = 1'b0;
        #1;
        chk("s6_rst_gnt",    {4'd0, gnt},         8'h00);
        chk("s6_rst_gnt_id", {6'd0, gnt_id},      8'h00);
        chk("s6_rst_busy",   {7'd0, busy},        8'h00);
        chk("s6_rst_end",    {7'd0, line_end},    8'h00);
        chk("s6_rst_dial",   {7'd0, line_dial},   8'h00);
        chk("s6_rst_cancel", {7'd0, line_cancel}, 8'h00);
        chk("s6_rst_state",  {5'd0, state_dbg},   {5'd0, S_IDLE});
        tick();
        line_in_call = 1'b0;
        req          = 4'b1000;
        reset_n      = 1'b1;
        tick();
        chk("s6_gnt_after",    {4'd0, gnt},    8'h08);
        chk("s6_gnt_id_after", {6'd0, gnt_id}, 8'h03);
        tick();
        // Far end hangs up while the handset also releases: no end strobe.
        line_call_ended = 1'b1;
        line_in_call    = 1'b1;
        rel             = 4'b1000;
        #1;
        chk("s6_ended_no_end", {7'd0, line_end}, 8'h00);
        tick();
        clear_inputs();
        chk("s6_ended_release", {5'd0, state_dbg}, {5'd0, S_RELEASE});
        to_idle();

        // ptr=3 after reset: handset 0 beats handset 3.
        do_reset();
        req = 4'b1001;
        tick();
        chk("s7_prio_gnt", {4'd0, gnt}, 8'h01);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
